pc_gen_bp: RTL and testbench
============================

PC_GEN_BP -- requirements
Module: pc_gen_bp

Interface
REQ-001 The module SHALL have parameter PC_W, default 30, width of the word-address PC (bits [31:2] of the byte address), legal range 27..30.
REQ-002 The module SHALL have parameter BHT_DEPTH, default 64, number of branch-history entries, power of two in 4..1024; IDX_W = log2(BHT_DEPTH).
REQ-003 The module SHALL have parameter RESET_PC, default 30'h00000C00 (byte address 0x00003000), the word address loaded on reset.
REQ-004 The module SHALL have parameter CNT_W, default 32, width of the statistics counters.
REQ-005 The module SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The module SHALL have port stall, input, 1, holding the PC when high.
REQ-008 The module SHALL have port if_branch, input, 1, marking the instruction at pc as a conditional branch.
REQ-009 The module SHALL have port if_jump, input, 1, marking the instruction at pc as j/jal.
REQ-010 The module SHALL have port imm16, input, 16, branch offset of the instruction at pc.
REQ-011 The module SHALL have port target26, input, 26, jump target field of the instruction at pc.
REQ-012 The module SHALL have port ex_br_valid, input, 1, marking a branch resolved this cycle in EX.
REQ-013 The module SHALL have port ex_taken, input, 1, the actual branch outcome.
REQ-014 The module SHALL have port ex_pred, input, 1, the prediction carried down the pipe with that branch.
REQ-015 The module SHALL have port ex_pc, input, PC_W, the word address of the resolved branch.
REQ-016 The module SHALL have port ex_target, input, PC_W, the computed branch target of the resolved branch.
REQ-017 The module SHALL have port pc, output, PC_W, the registered fetch word address.
REQ-018 The module SHALL have port pred_taken, output, 1, the combinational prediction for pc; 0 when if_branch=0.
REQ-019 The module SHALL have port flush, output, 1, the combinational mispredict indication.
REQ-020 The module SHALL have port br_cnt, output, CNT_W, the count of resolved branches.
REQ-021 The module SHALL have port miss_cnt, output, CNT_W, the count of mispredicts.

Function
REQ-022 flush SHALL equal ex_br_valid AND (ex_taken XOR ex_pred).
REQ-023 Next pc SHALL be selected in strict priority: flush -> (ex_taken ? ex_target : ex_pc+1); else stall -> pc; else if_jump -> {pc[PC_W-1:26], target26}; else if_branch AND pred_taken -> pc+1+sext(imm16); else pc+1.
REQ-024 All PC arithmetic SHALL be modulo 2^PC_W; imm16 SHALL be sign-extended to PC_W; 0x3FFFFFFF+1 SHALL wrap to 0.
REQ-025 The BHT SHALL hold BHT_DEPTH 2-bit saturating counters indexed by pc[IDX_W-1:0] for lookup and by ex_pc[IDX_W-1:0] for update.
REQ-026 pred_taken SHALL be the MSB of the looked-up counter AND if_branch.
REQ-027 On ex_br_valid the indexed counter SHALL increment if ex_taken and decrement otherwise, saturating at 3 and 0, independent of stall.
REQ-028 A same-cycle lookup and update to the same index SHALL return the pre-update value.
REQ-029 br_cnt SHALL increment on every ex_br_valid, and miss_cnt on every flush, both saturating at all-ones.
REQ-030 Prediction latency SHALL be zero cycles and redirect latency SHALL be one edge: pc equals the corrected address in the cycle after flush.

Reset
REQ-031 When rst=1 at an edge, pc SHALL become RESET_PC, every BHT counter SHALL become 2'b01 (weakly not-taken), and br_cnt and miss_cnt SHALL become 0; rst SHALL override flush, stall and ex_br_valid.
REQ-032 Reset asserted mid-redirect SHALL discard the pending BHT update.

Structure
REQ-033 Counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the RESET_PC default SHALL live in the shared package.
REQ-034 The BHT SHALL be a sub-module, bht_2bit (BHT_DEPTH, IDX_W), with one combinational read port and one synchronous update port.

Verification
REQ-035 Reset test: rst for 1 cycle -> pc=0x00000C00, br_cnt=0, miss_cnt=0, and pred_taken=0 for any branch.
REQ-036 Sequential test: no branch or jump for 3 cycles -> pc runs 0xC00, 0xC01, 0xC02, 0xC03; with stall=1 -> pc holds.
REQ-037 Jump test: pc=0x0C00 with if_jump and target26=0x0000100 -> next pc=0x0000100.
REQ-038 Training test: branch at pc 0xC04 with imm16=0xFFFE resolved taken twice -> counter=3; next fetch at 0xC04 -> pred_taken=1, next pc=0xC03.
REQ-039 Mispredict test: ex_br_valid=1, ex_pred=1, ex_taken=0, ex_pc=0xC04, with stall=1 and if_jump=1 in the same cycle -> flush=1, next pc=0xC05, miss_cnt+1.
REQ-040 Wrap test: pc=0x3FFFFFFF with no control flow -> next pc=0; a 0x7FFF offset wraps likewise.

Source files
------------

// File: rtl/pc_gen_bp_pkg.sv
// Shared types and constants for the fetch PC generator and its branch history table.
// Holds the 2-bit counter encoding, the default reset address and the counter update rule.
package pc_gen_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_cnt_e;

    // Word address of byte address 0x0000_3000.
    localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;

    // Saturating step of one 2-bit counter toward the resolved outcome.
    function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = bht_cnt_e'(cur + 2'd1);
            end
        end else if (cur != SNT) begin
            nxt = bht_cnt_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

    function automatic logic bht_predict(input bht_cnt_e cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/pc_gen_bp_bht.sv
// Branch history table: BHT_DEPTH 2-bit saturating counters, one combinational
// read port for fetch and one synchronous update port driven from EX.
module bht_2bit
    import pc_gen_bp_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_e         rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_cnt_e cnt_q [BHT_DEPTH];

    // A same-cycle update to rd_idx is only visible after the edge, so fetch
    // always sees the pre-update counter.
    assign rd_cnt = cnt_q[rd_idx];

    // NOTE: the table is kept in flops rather than a RAM macro so every entry can
    // be forced to weakly-not-taken in a single reset cycle; a RAM would need a
    // multi-cycle clearing sequence before the first prediction is trustworthy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (upd_en) begin
            cnt_q[upd_idx] <= bht_next(cnt_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/pc_gen_bp.sv
// Fetch PC generator with a 2-bit bimodal branch predictor, mispredict redirect
// and saturating branch / mispredict statistics.
module pc_gen_bp
    import pc_gen_bp_pkg::*;
#(
    parameter int unsigned     PC_W      = 30,
    parameter int unsigned     BHT_DEPTH = 64,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEFAULT),
    parameter int unsigned     CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_branch,
    input  logic             if_jump,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    input  logic             ex_br_valid,
    input  logic             ex_taken,
    input  logic             ex_pred,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  ex_target,
    output logic [PC_W-1:0]  pc,
    output logic             pred_taken,
    output logic             flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_br;
    logic [PC_W-1:0]  pc_jmp;
    logic [PC_W-1:0]  imm_sext;
    bht_cnt_e         lookup_cnt;

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_q[IDX_W-1:0]),
        .rd_cnt    (lookup_cnt),
        .upd_en    (ex_br_valid),
        .upd_idx   (ex_pc[IDX_W-1:0]),
        .upd_taken (ex_taken)
    );

    assign pred_taken = if_branch & bht_predict(lookup_cnt);
    assign flush      = ex_br_valid & (ex_taken ^ ex_pred);

    // All address arithmetic wraps naturally at PC_W bits.
    assign imm_sext = {{(PC_W-16){imm16[15]}}, imm16};
    assign pc_seq   = pc_q + PC_W'(1);
    assign pc_br    = pc_seq + imm_sext;
    assign pc_jmp   = {pc_q[PC_W-1:26], target26};

    // NOTE: every always_comb output gets a default on its first line, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        pc_d = pc_seq;
        if (flush) begin
            pc_d = ex_taken ? ex_target : (ex_pc + PC_W'(1));
        end else if (stall) begin
            pc_d = pc_q;
        end else if (if_jump) begin
            pc_d = pc_jmp;
        end else if (pred_taken) begin
            pc_d = pc_br;
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (ex_br_valid && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (flush && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign pc       = pc_q;
    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_pc_gen_bp.sv
// Randomized and directed bench for pc_gen_bp against a behavioural model that
// tracks the fetch address, counter table and statistics with plain arithmetic.
module tb_pc_gen_bp;

    localparam longint MOD      = 64'h4000_0000;
    localparam longint RST_PC   = 64'h0C00;
    localparam int     DEPTH    = 64;
    localparam longint CNT_MAX  = 64'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_branch;
    logic        if_jump;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic        ex_br_valid;
    logic        ex_taken;
    logic        ex_pred;
    logic [29:0] ex_pc;
    logic [29:0] ex_target;
    logic [29:0] pc;
    logic        pred_taken;
    logic        flush;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    longint m_pc;
    longint m_br;
    longint m_miss;
    int     m_bht [DEPTH];

    pc_gen_bp dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .if_branch   (if_branch),
        .if_jump     (if_jump),
        .imm16       (imm16),
        .target26    (target26),
        .ex_br_valid (ex_br_valid),
        .ex_taken    (ex_taken),
        .ex_pred     (ex_pred),
        .ex_pc       (ex_pc),
        .ex_target   (ex_target),
        .pc          (pc),
        .pred_taken  (pred_taken),
        .flush       (flush),
        .br_cnt      (br_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; stall = 0; if_branch = 0; if_jump = 0;
        imm16 = '0; target26 = '0;
        ex_br_valid = 0; ex_taken = 0; ex_pred = 0; ex_pc = '0; ex_target = '0;
    endtask

    // One clock: check combinational outputs against the model, advance the
    // model by the rules, then check the registered state after the edge.
    task automatic step(input string tag, input bit chk_comb);
        bit     e_flush, e_pred;
        longint nxt;
        int     idx;
        e_flush = ex_br_valid && (ex_taken != ex_pred);
        e_pred  = if_branch && (m_bht[int'(m_pc % DEPTH)] >= 2);
        #1;
        if (chk_comb) begin
            check({tag, ".flush"}, 64'(flush), 64'(e_flush));
            check({tag, ".pred"}, 64'(pred_taken), 64'(e_pred));
        end
        if (rst) begin
            m_pc = RST_PC; m_br = 0; m_miss = 0;
            for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        end else begin
            if (e_flush)
                nxt = ex_taken ? longint'(ex_target) : (longint'(ex_pc) + 1) % MOD;
            else if (stall)
                nxt = m_pc;
            else if (if_jump)
                nxt = (m_pc / 64'h400_0000) * 64'h400_0000 + longint'(target26);
            else if (e_pred)
                nxt = (((m_pc + 1 + longint'($signed(imm16))) % MOD) + MOD) % MOD;
            else
                nxt = (m_pc + 1) % MOD;
            if (ex_br_valid) begin
                idx = int'(longint'(ex_pc) % DEPTH);
                if (ex_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else          m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                if (m_br < CNT_MAX) m_br++;
            end
            if (e_flush && m_miss < CNT_MAX) m_miss++;
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
        check({tag, ".pc"}, 64'(pc), 64'(m_pc));
        check({tag, ".br_cnt"}, 64'(br_cnt), 64'(m_br));
        check({tag, ".miss_cnt"}, 64'(miss_cnt), 64'(m_miss));
    endtask

    task automatic do_reset(input string tag, input bit chk_comb);
        idle();
        rst = 1;
        step(tag, chk_comb);
        idle();
    endtask

    initial begin
        idle();
        m_pc = 0; m_br = 0; m_miss = 0;
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 0;
        @(posedge clk);
        #1;

        // Reset, then a branch right after must not be predicted taken.
        do_reset("reset", 1'b0);
        check("reset.pc_const", 64'(pc), 64'h0C00);
        if_branch = 1; imm16 = 16'h0010;
        #1;
        check("reset.pred_const", 64'(pred_taken), 64'd0);
        step("reset.branch", 1'b1);

        // Sequential run and stall hold.
        do_reset("seq.rst", 1'b1);
        for (int i = 0; i < 3; i++) step("seq", 1'b1);
        check("seq.pc_const", 64'(pc), 64'h0C03);
        stall = 1;
        step("seq.stall", 1'b1);
        check("seq.stall_const", 64'(pc), 64'h0C03);
        idle();

        // Jump from the reset address.
        do_reset("jump.rst", 1'b1);
        if_jump = 1; target26 = 26'h000_0100;
        step("jump", 1'b1);
        check("jump.pc_const", 64'(pc), 64'h0100);
        idle();

        // Train the counter of 0xC04 to strongly taken, then fetch it.
        do_reset("train.rst", 1'b1);
        for (int i = 0; i < 2; i++) begin
            ex_br_valid = 1; ex_taken = 1; ex_pred = 1; ex_pc = 30'h0C04;
            step("train.upd", 1'b1);
        end
        idle();
        step("train.seq", 1'b1);
        step("train.seq", 1'b1);
        if_branch = 1; imm16 = 16'hFFFE;
        #1;
        check("train.pred_const", 64'(pred_taken), 64'd1);
        step("train.fetch", 1'b1);
        check("train.pc_const", 64'(pc), 64'h0C03);
        idle();

        // Mispredict overrides stall and jump.
        stall = 1; if_jump = 1; target26 = 26'h123_4567;
        ex_br_valid = 1; ex_pred = 1; ex_taken = 0; ex_pc = 30'h0C04; ex_target = 30'h0000_7777;
        #1;
        check("miss.flush_const", 64'(flush), 64'd1);
        step("miss", 1'b1);
        check("miss.pc_const", 64'(pc), 64'h0C05);
        check("miss.cnt_const", 64'(miss_cnt), 64'd1);
        idle();

        // Wrap of the sequential increment at the top of the address space.
        ex_br_valid = 1; ex_taken = 1; ex_pred = 0; ex_pc = 30'h0000_0001; ex_target = 30'h3FFF_FFFF;
        step("wrap.redirect", 1'b1);
        idle();
        step("wrap.seq", 1'b1);
        check("wrap.pc_const", 64'(pc), 64'h0);

        // Wrap of a taken +0x7FFF branch from 0x3FFFFFF0.
        for (int i = 0; i < 2; i++) begin
            ex_br_valid = 1; ex_taken = 1; ex_pred = 1; ex_pc = 30'h0000_0030;
            step("wrap.train", 1'b1);
        end
        ex_br_valid = 1; ex_taken = 1; ex_pred = 0; ex_pc = 30'h0000_0002; ex_target = 30'h3FFF_FFF0;
        step("wrap.redirect2", 1'b1);
        idle();
        if_branch = 1; imm16 = 16'h7FFF;
        step("wrap.branch", 1'b1);
        check("wrap.br_pc_const", 64'(pc), 64'h7FF0);
        idle();

        // Reset during a redirect discards the pending counter update.
        ex_br_valid = 1; ex_taken = 1; ex_pred = 0; ex_pc = 30'h0000_0C00; ex_target = 30'h0000_1234;
        rst = 1;
        step("rstmid", 1'b1);
        idle();
        if_branch = 1; imm16 = 16'h0004;
        step("rstmid.fetch", 1'b1);
        idle();

        // Randomized traffic, with EX updates often aliasing the fetch index.
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 59) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            if_branch   = ($urandom_range(0, 2) == 0);
            if_jump     = ($urandom_range(0, 5) == 0);
            imm16       = 16'($urandom);
            target26    = 26'($urandom);
            ex_br_valid = ($urandom_range(0, 1) == 1);
            ex_taken    = ($urandom_range(0, 1) == 1);
            ex_pred     = ($urandom_range(0, 2) != 0) ? ex_taken : !ex_taken;
            if ($urandom_range(0, 1) == 1)
                ex_pc = 30'(($urandom & 32'h3FFF_FFC0) | 32'(m_pc % DEPTH));
            else
                ex_pc = 30'($urandom);
            ex_target   = 30'($urandom);
            step("rand", 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
